alu_operand_loader: RTL

//  Operator-entry front end for the board-level 4-bit ALU: the user keys A, B and the opcode
//  one after another on the same slide switches, confirming each with a push button.

---
 rtl/alu_operand_loader_if.sv | 19 +
 rtl/alu_operand_loader.sv | 110 +++++++++++
 2 files changed

// File: rtl/alu_operand_loader_if.sv
// Switch/button inputs and registered ALU operand outputs of the operand loader.
interface alu_operand_loader_if #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 3
);
  logic [WIDTH-1:0] sw;
  logic             btn_load_n;
  logic             btn_clr_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             valid;
  logic [1:0]       state_led;

  modport master (output sw, btn_load_n, btn_clr_n,
                  input  a, b, op, valid, state_led);
  modport slave  (input  sw, btn_load_n, btn_clr_n,
                  output a, b, op, valid, state_led);
endinterface

// File: rtl/alu_operand_loader.sv
// Operator-entry front end for the 4-bit ALU: synchronised/debounced buttons sequence
// capture of A, B and opcode from shared slide switches into registered outputs.
module alu_operand_loader #(
  parameter int WIDTH     = 4,
  parameter int OP_W      = 3,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_operand_loader_if.slave io
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int NB = 2;  // bit 0 = load, bit 1 = clear

  typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, LOAD_OP = 2'b10, SHOW = 2'b11} state_t;

  logic [WIDTH-1:0]       sw_s1, sw_s2;
  logic [NB-1:0]          btn_s1, btn_s2, deb, deb_q, press;
  logic [NB-1:0][CW-1:0]  cnt;
  state_t                 state;
  logic [WIDTH-1:0]       a_r, b_r;
  logic [OP_W-1:0]        op_r;
  logic                   valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '1;
      sw_s2  <= '1;
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      sw_s1  <= io.sw;
      sw_s2  <= sw_s1;
      btn_s1 <= {io.btn_clr_n, io.btn_load_n};
      btn_s2 <= btn_s1;
    end
  end

  // A level is accepted only after DB_CYCLES consecutive samples differing from the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '1;
      cnt <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (btn_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          deb[i] <= btn_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '1;
      press <= '0;
    end else begin
      deb_q <= deb;
      press <= deb_q & ~deb;
    end
  end

  // Clear has priority; a simultaneous load event is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD_A;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      valid_r <= 1'b0;
    end else if (press[1]) begin
      state   <= LOAD_A;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      valid_r <= 1'b0;
    end else if (press[0]) begin
      case (state)
        LOAD_A: begin
          a_r   <= sw_s2;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b_r   <= sw_s2;
          state <= LOAD_OP;
        end
        LOAD_OP: begin
          op_r    <= sw_s2[OP_W-1:0];
          valid_r <= 1'b1;
          state   <= SHOW;
        end
        default: begin
          valid_r <= 1'b0;
          state   <= LOAD_A;
        end
      endcase
    end
  end

  assign io.a         = a_r;
  assign io.b         = b_r;
  assign io.op        = op_r;
  assign io.valid     = valid_r;
  assign io.state_led = state;
endmodule
